// File: rtl/rr_shift_reg_seq_pkg.sv
// rr_shift_reg_seq_pkg: command/state encodings and default geometry
// shared by the shift register sequencer and its next-value mux.
package rr_shift_reg_seq_pkg;
   localparam int DEF_WORD_W = 16;
   localparam int DEF_NWORDS = 16;
   localparam int DEF_CNT_W = 9;
   typedef enum logic [1:0] {OP_SHR = 2'b00, OP_ROR = 2'b01, OP_EMIT = 2'b10, OP_RSVD = 2'b11} op_t;
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_EMIT} state_t;
   typedef enum logic [1:0] {ST_HOLD, ST_LOAD, ST_SHIFT, ST_WROT} step_t;
endpackage

// File: rtl/rr_shift_reg_seq_if.sv
// rr_shift_reg_seq_if: load, command and emit handshakes of the shift register sequencer.
interface rr_shift_reg_seq_if #(
   parameter int WORD_W = 16,
   parameter int NWORDS = 16,
   parameter int CNT_W = 9
);
   localparam int WCW = $clog2(NWORDS + 1);
   logic in_valid;
   logic in_ready;
   logic [WORD_W-1:0] in_word;
   logic cmd_valid;
   logic cmd_ready;
   logic [1:0] cmd_op;
   logic [CNT_W-1:0] cmd_cnt;
   logic msb_in;
   logic lsb_out;
   logic [WORD_W-1:0] regout;
   logic out_valid;
   logic out_ready;
   logic busy;
   logic done;
   logic [WCW-1:0] word_cnt;
   logic full;
   modport master (
      output in_valid, in_word, cmd_valid, cmd_op, cmd_cnt, msb_in, out_ready,
      input in_ready, cmd_ready, lsb_out, regout, out_valid, busy, done, word_cnt, full
   );
   modport slave (
      input in_valid, in_word, cmd_valid, cmd_op, cmd_cnt, msb_in, out_ready,
      output in_ready, cmd_ready, lsb_out, regout, out_valid, busy, done, word_cnt, full
   );
endinterface

// File: rtl/rr_shift_step.sv
// rr_shift_step: next-value mux for the operand register
// (hold, word load at the top, 1-bit right shift with fill, rotate right by one word).
module rr_shift_step
   import rr_shift_reg_seq_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W,
   parameter int NWORDS = DEF_NWORDS
) (
   input  logic [WORD_W*NWORDS-1:0] cur,
   input  logic [WORD_W-1:0]        word,
   input  logic                     fill,
   input  step_t                    sel,
   output logic [WORD_W*NWORDS-1:0] nxt
);
   localparam int W = WORD_W * NWORDS;
   always_comb
      nxt = sel == ST_LOAD  ? {word, cur[W-1:WORD_W]} :
            sel == ST_SHIFT ? {fill, cur[W-1:1]} :
            sel == ST_WROT  ? {cur[WORD_W-1:0], cur[W-1:WORD_W]} : cur;
endmodule

// File: rtl/rr_shift_reg_seq.sv
// rr_shift_reg_seq: word-loaded operand register with sequenced multi-cycle
// right shift/rotate and word-by-word emit, signalling completion with done.
module rr_shift_reg_seq
   import rr_shift_reg_seq_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W,
   parameter int NWORDS = DEF_NWORDS,
   parameter int CNT_W = DEF_CNT_W
) (
   input logic clk,
   input logic rst_n,
   input logic clr,
   rr_shift_reg_seq_if.slave bus
);
   localparam int W = WORD_W * NWORDS;
   localparam int WCW = $clog2(NWORDS + 1);
   state_t state;
   logic [W-1:0] r;
   logic [W-1:0] nxt;
   logic [CNT_W-1:0] cnt;
   logic [WCW-1:0] wc;
   logic rot;
   logic done_q;
   logic load;
   logic xfer;
   logic fill;
   logic go_shift;
   step_t sel;
   assign load = bus.in_valid && bus.in_ready;
   assign xfer = state == S_EMIT && bus.out_ready;
   assign fill = rot ? r[0] : bus.msb_in;
   assign go_shift = (bus.cmd_op == OP_SHR || bus.cmd_op == OP_ROR) && bus.cmd_cnt != '0;
   assign sel = load ? ST_LOAD : state == S_SHIFT ? ST_SHIFT : xfer ? ST_WROT : ST_HOLD;
   assign bus.cmd_ready = state == S_IDLE;
   assign bus.in_ready = state == S_IDLE && !bus.cmd_valid;
   assign bus.busy = state != S_IDLE;
   assign bus.out_valid = state == S_EMIT;
   assign bus.done = done_q;
   assign bus.lsb_out = r[0];
   assign bus.regout = r[WORD_W-1:0];
   assign bus.word_cnt = wc;
   assign bus.full = wc == WCW'(NWORDS);

   rr_shift_step #(.WORD_W(WORD_W), .NWORDS(NWORDS)) u_step (
      .cur(r), .word(bus.in_word), .fill(fill), .sel(sel), .nxt(nxt)
   );

   // NWORDS word rotations during EMIT bring the register back to its pre-EMIT value
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= S_IDLE;
         r <= '0;
         cnt <= '0;
         wc <= '0;
         rot <= 1'b0;
         done_q <= 1'b0;
      end else if (clr) begin
         state <= S_IDLE;
         r <= '0;
         cnt <= '0;
         wc <= '0;
         rot <= 1'b0;
         done_q <= 1'b0;
      end else begin
         r <= nxt;
         done_q <= 1'b0;
         if (load && wc != WCW'(NWORDS)) wc <= wc + 1'b1;
         case (state)
            S_IDLE:
               if (bus.cmd_valid) begin
                  if (go_shift) begin
                     state <= S_SHIFT;
                     cnt <= bus.cmd_cnt;
                     rot <= bus.cmd_op == OP_ROR;
                  end else if (bus.cmd_op == OP_EMIT) begin
                     state <= S_EMIT;
                     cnt <= CNT_W'(NWORDS);
                  end else done_q <= 1'b1;
               end
            S_SHIFT: begin
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  state <= S_IDLE;
                  done_q <= 1'b1;
               end
            end
            S_EMIT:
               if (bus.out_ready) begin
                  cnt <= cnt - 1'b1;
                  if (cnt == CNT_W'(1)) begin
                     state <= S_IDLE;
                     done_q <= 1'b1;
                  end
               end
            default: state <= S_IDLE;
         endcase
      end
endmodule

// File: doc/rr_shift_reg_seq.md
Name: rr_shift_reg_seq

Overview:
Parametrised, sequenced successor to the 256-bit right-shift operand register used by the modular multiply/divide datapath.
- Loads the operand a word at a time over a valid/ready handshake.
- Performs multi-cycle right shifts or rotates by a commanded bit count, with an internal counter.
- Streams the full contents back out word by word.
- Signals completion with a done pulse.
- Sits between the operand bus and the bit-serial modular arithmetic core.

Parameters:
WORD_W, 16, bits per load/emit word
NWORDS, 16, number of words; total register width W = WORD_W*NWORDS (256)
CNT_W, 9, width of shift count; must be >= clog2(W+1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear
in_valid  in  1  load word valid
in_ready  out  1  load word ready
in_word  in  WORD_W  word shifted in at the top
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_op  in  2  00 SHR, 01 ROR, 10 EMIT, 11 reserved
cmd_cnt  in  CNT_W  bit count for SHR/ROR
msb_in  in  1  fill bit for SHR, sampled every shift cycle
lsb_out  out  1  reg[0]
regout  out  WORD_W  reg[WORD_W-1:0]
out_valid  out  1  EMIT word valid
out_ready  in  1  EMIT consumer ready
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after command completes
word_cnt  out  clog2(NWORDS+1)  words loaded, saturating at NWORDS
full  out  1  word_cnt == NWORDS

Behaviour:
- Reset (rst_n low, async):
  - reg = 0, word_cnt = 0, state IDLE, shift counter = 0.
  - done = 0, out_valid = 0.
- clr (sync): highest priority after reset.
  - Same values as reset on the next edge.
  - Aborts any command without a done pulse.
- States: IDLE, SHIFT, EMIT.
- cmd_ready = (state == IDLE).
- in_ready = (state == IDLE) && !cmd_valid. A command wins over a load in the same cycle.
- Load (in_valid && in_ready):
  - reg <= {in_word, reg[W-1:WORD_W]}.
  - word_cnt increments, saturating at NWORDS.
  - After NWORDS loads, the first-loaded word is in regout.
- Command accept in IDLE:
  - SHR/ROR with cmd_cnt != 0: cnt <= cmd_cnt, go to SHIFT.
  - SHR/ROR with cmd_cnt == 0, or op 11: no change; done pulses the next cycle.
  - EMIT: cnt <= NWORDS, go to EMIT.
- SHIFT, one bit per cycle:
  - SHR: reg <= {msb_in, reg[W-1:1]}.
  - ROR: reg <= {reg[0], reg[W-1:1]}.
  - cnt decrements; on the cycle cnt == 1, return to IDLE and assert done on the following cycle.
  - Latency: cmd_cnt cycles busy, done at accept + cmd_cnt + 1.
  - cmd_cnt > W is legal: SHR fills entirely with msb_in history; ROR wraps modulo W.
- EMIT:
  - out_valid = 1, data on regout.
  - On out_valid && out_ready: reg <= {reg[WORD_W-1:0], reg[W-1:WORD_W]} (rotate by a word) and cnt decrements.
  - After NWORDS transfers, return to IDLE and pulse done. reg is restored to its pre-EMIT value.
  - With out_ready low, reg and regout hold stable.
- word_cnt is unchanged by SHIFT/EMIT.
- Loads and commands are ignored while busy (in_ready = cmd_ready = 0).
- rst_n asserted mid-operation: immediate return to reset values, no done.

Decomposition:
- Shared include file: op encodings (OP_SHR, OP_ROR, OP_EMIT), state encodings, default WORD_W/NWORDS.
- One sub-module, rr_shift_step: combinational next-reg mux (hold / word load / 1-bit shift with fill / word rotate), parametrised on WORD_W and NWORDS.
- Control FSM and counters live in the top.

Test Plan:
- Reset: hold rst_n low for 3 cycles, release -> regout = 0, busy = 0, done = 0, word_cnt = 0, in_ready = 1.
- Load: send 16 words 0x0001..0x0010 with in_valid gaps -> word_cnt = 16, full = 1, regout = 0x0001. A 17th word 0xAAAA -> regout = 0x0002, word_cnt stays 16.
- SHR: load word0 = 0x00F0, rest 0; SHR cnt = 4, msb_in = 1 -> busy for 4 cycles, regout = 0x000F, reg[255:252] = 0xF, done at accept + 5.
- ROR: load a known pattern; ROR cnt = 256 -> reg unchanged, busy 256 cycles, single done pulse. ROR cnt = 1 on reg = 1 -> reg[255] = 1, regout = 0.
- EMIT with backpressure: load 0x0001..0x0010; EMIT with out_ready toggling 1/0 -> out words 0x0001..0x0010 in order, regout stable while stalled, reg unchanged after done.
- Abort and corner cases:
  - clr on the 2nd cycle of SHR cnt = 10 -> reg = 0, busy = 0 next cycle, no done.
  - SHR cnt = 0 -> done next cycle, reg unchanged.
  - cmd_valid and in_valid in the same IDLE cycle -> command taken, word not loaded.
